// File: rtl/rcpu_uart_tx_if.sv
// RCPU memory-bus responder interface: the CPU drives address/data/strobe,
// and the peripheral answers with read data and a window-select flag.
interface rcpu_uart_tx_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        sel;

    modport master (output addr, output wdata, output we, input rdata, input sel);
    modport slave  (input addr, input wdata, input we, output rdata, output sel);
endinterface

// File: rtl/rcpu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a four-register window feeds a
// circular transmit FIFO that a start/data/stop serializer drains onto o_tx.
module rcpu_uart_tx #(
    parameter logic [15:0] BASE      = 16'hD000,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic            i_clk,
    input  logic            i_rst,
    rcpu_uart_tx_if.slave   bus,
    output logic            o_tx,
    output logic            o_irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [15:0]     r_divisor;
    logic            r_enable;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic [15:0]     r_reload;
    logic [15:0]     r_timer;
    logic            r_tx;
    logic            r_irq;
    logic            r_busy;

    logic            w_sel;
    logic [1:0]      w_off;
    logic            w_wr_tx;
    logic            w_wr_st;
    logic            w_wr_div;
    logic            w_wr_ctl;
    logic            w_empty;
    logic            w_full;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_can_pop;
    logic            w_tick;
    logic [7:0]      w_head;
    logic [7:0]      w_shift_next;
    logic [2:0]      w_bit_next;
    logic [15:0]     w_reload_next;
    logic [15:0]     w_timer_next;
    logic            w_tx_next;
    logic [3:0]      w_cnt4;
    logic [15:0]     w_rdata;

    always_comb begin
        w_sel     = (bus.addr[15:2] == BASE[15:2]);
        w_off     = bus.addr[1:0];
        w_wr_tx   = w_sel && bus.we && (w_off == 2'd0);
        w_wr_st   = w_sel && bus.we && (w_off == 2'd1);
        w_wr_div  = w_sel && bus.we && (w_off == 2'd2);
        w_wr_ctl  = w_sel && bus.we && (w_off == 2'd3);
        w_empty   = (r_count == CW'(0));
        w_full    = (r_count == CW'(DEPTH));
        // Fullness is judged on pre-edge state, so a same-edge pop never frees a slot.
        w_push_ok = w_wr_tx && !w_full;
        w_head    = r_mem[r_rd_ptr];
        w_tick    = (r_timer == 16'd0);
        w_can_pop = r_enable && !w_empty;
        w_cnt4    = 4'(r_count);
    end

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_timer_next  = r_timer;
        w_shift_next  = r_shift;
        w_bit_next    = r_bit_idx;
        w_reload_next = r_reload;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop         = 1'b1;
                    w_reload_next = r_divisor;
                    w_timer_next  = r_divisor;
                    w_shift_next  = w_head;
                    w_state_next  = S_START;
                end else begin
                    w_state_next  = S_IDLE;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                    w_timer_next = r_reload;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_timer_next = r_reload;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next   = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    // Chain straight into the next start bit when more data waits.
                    if (w_can_pop) begin
                        w_pop         = 1'b1;
                        w_reload_next = r_divisor;
                        w_timer_next  = r_divisor;
                        w_shift_next  = w_head;
                        w_state_next  = S_START;
                    end else begin
                        w_timer_next  = 16'd0;
                        w_state_next  = S_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_reload  <= 16'd0;
            r_timer   <= 16'd0;
            r_tx      <= 1'b1;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_next;
            r_reload  <= w_reload_next;
            r_timer   <= w_timer_next;
            r_tx      <= w_tx_next;
            r_irq     <= (r_state == S_IDLE) && w_empty;
            r_busy    <= (r_state != S_IDLE);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= bus.wdata[7:0];
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
            r_divisor  <= DIV_RESET;
            r_enable   <= 1'b1;
        end else begin
            if (w_wr_tx && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr_st && bus.wdata[3]) begin
                r_overflow <= 1'b0;
            end
            if (w_wr_div) begin
                r_divisor <= bus.wdata;
            end
            if (w_wr_ctl) begin
                r_enable <= bus.wdata[0];
            end
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        if (w_sel) begin
            case (w_off)
                2'd1:    w_rdata = {4'h0, w_cnt4, 4'h0, r_overflow, r_busy, w_full, w_empty};
                2'd2:    w_rdata = r_divisor;
                2'd3:    w_rdata = {15'h0000, r_enable};
                default: w_rdata = 16'h0000;
            endcase
        end else begin
            w_rdata = 16'h0000;
        end
        bus.rdata = w_rdata;
        bus.sel   = w_sel;
    end

    assign o_tx  = r_tx;
    assign o_irq = r_irq;

endmodule
